// File: rtl/matrix_tile_unloader.sv
// matrix_tile_unloader
//   Captures one transposed tile from the transpose core in a single cycle,
//   then streams it out one element per cycle over valid/ready. Each element
//   carries its byte store address. A new tile can be captured on the same
//   edge as the final handshake of the current tile, so back-to-back tiles
//   drain without a bubble.
//
// Ports
//   clk, rst        clock / asynchronous active-low reset
//   in_val, in_rdy  tile handshake with the transpose core
//   tile_elements   parallel tile, tile_elements[i][j], i = MG row, j = PE col
//   tile_addr       byte base address of the tile
//   out_valid/ready element stream handshake
//   out_data        element tile[i][j]
//   out_addr        base + (i*NUM_PE + j)*(DATA_WIDTH/8), wraps mod 2^ADDR_WIDTH
//   out_last        final element of the tile
//   busy            a tile is buffered and not yet fully drained
module matrix_tile_unloader #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG     = 16,
  parameter int NUM_PE     = NUM_MG,
  parameter int ADDR_WIDTH = 64,
  parameter bit ROW_MAJOR  = 1'b1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           in_val,
  output logic                                           in_rdy,
  input  logic [NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0]  tile_elements,
  input  logic [ADDR_WIDTH-1:0]                          tile_addr,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [DATA_WIDTH-1:0]                          out_data,
  output logic [ADDR_WIDTH-1:0]                          out_addr,
  output logic                                           out_last,
  output logic                                           busy
);

  localparam int MW = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [ADDR_WIDTH-1:0] PE_A = ADDR_WIDTH'(NUM_PE);
  localparam logic [ADDR_WIDTH-1:0] EB_A = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [MW-1:0] I_MAX = MW'(NUM_MG - 1);
  localparam logic [PW-1:0] J_MAX = PW'(NUM_PE - 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                                          state_q, state_d;
  logic [MW-1:0]                                   i_q, i_d;
  logic [PW-1:0]                                   j_q, j_d;
  logic [ADDR_WIDTH-1:0]                           base_q, base_d;
  logic [NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0]   tile_q, tile_d;

  logic drain, at_last, hs, ld;

  assign drain   = (state_q == DRAIN);
  assign at_last = drain && (i_q == I_MAX) && (j_q == J_MAX);
  assign hs      = drain && out_ready;
  // Only combinational path: out_ready lets the next tile in on the last beat.
  assign in_rdy  = !drain || (at_last && out_ready);
  assign ld      = in_val && in_rdy;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    base_d  = base_q;
    tile_d  = tile_q;
    if (ld) begin
      state_d = DRAIN;
      i_d     = '0;
      j_d     = '0;
      base_d  = tile_addr;
      tile_d  = tile_elements;
    end else if (hs) begin
      if (at_last) state_d = IDLE;
      // Both indices wrap to 0 on the last beat, so IDLE starts clean.
      if (ROW_MAJOR) begin
        if (j_q == J_MAX) begin
          j_d = '0;
          i_d = (i_q == I_MAX) ? '0 : i_q + MW'(1);
        end else begin
          j_d = j_q + PW'(1);
        end
      end else begin
        if (i_q == I_MAX) begin
          i_d = '0;
          j_d = (j_q == J_MAX) ? '0 : j_q + PW'(1);
        end else begin
          i_d = i_q + MW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      base_q  <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      base_q  <= base_d;
      tile_q  <= tile_d;
    end
  end

  // Outputs decode directly from flops; forced to 0 outside DRAIN.
  assign out_valid = drain;
  assign busy      = drain;
  assign out_last  = at_last;
  assign out_data  = drain ? tile_q[i_q][j_q] : '0;
  assign out_addr  = drain ? base_q + ((ADDR_WIDTH'(i_q) * PE_A + ADDR_WIDTH'(j_q)) * EB_A)
                           : '0;

endmodule

// File: tb/tb_matrix_tile_unloader.sv
// Bench for matrix_tile_unloader: a row-major and a column-major instance
// share stimulus; each has its own expected-beat queue filled on tile accept
// and drained on every output handshake.
module tb_matrix_tile_unloader;

  localparam int DW = 64;
  localparam int NM = 4;
  localparam int NP = 4;
  localparam int AW = 64;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  logic                          clk, rst, in_val, out_ready;
  logic [NM-1:0][NP-1:0][DW-1:0] tile_el;
  logic [AW-1:0]                 tile_addr;
  logic [1:0]                    ov, rdy, lst, bsy;
  logic [DW-1:0]                 od [2];
  logic [AW-1:0]                 oa [2];

  exp_t          sb [2][$];
  bit            held [2];
  logic [DW-1:0] hd [2];
  logic [AW-1:0] ha [2];
  logic          hl [2];
  int            n_chk, n_pass;

  matrix_tile_unloader #(.DATA_WIDTH(DW), .NUM_MG(NM), .NUM_PE(NP), .ADDR_WIDTH(AW),
                         .ROW_MAJOR(1'b1)) dut_r (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(rdy[0]),
    .tile_elements(tile_el), .tile_addr(tile_addr),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_addr(oa[0]), .out_last(lst[0]), .busy(bsy[0]));

  matrix_tile_unloader #(.DATA_WIDTH(DW), .NUM_MG(NM), .NUM_PE(NP), .ADDR_WIDTH(AW),
                         .ROW_MAJOR(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(rdy[1]),
    .tile_elements(tile_el), .tile_addr(tile_addr),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_addr(oa[1]), .out_last(lst[1]), .busy(bsy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Expected beats for the tile currently on the inputs, in drain order.
  task automatic push_tile(input int d);
    exp_t e;
    for (int o = 0; o < 4; o++)
      for (int n = 0; n < 4; n++) begin
        int i, j;
        i = (d == 0) ? o : n;
        j = (d == 0) ? n : o;
        e.data = tile_el[i][j];
        e.addr = tile_addr + 64'((i * NP + j) * (DW / 8));
        e.last = (i == NM - 1) && (j == NP - 1);
        sb[d].push_back(e);
      end
  endtask

  // Monitor: samples on the falling edge, between input updates and the
  // rising edge on which the handshakes take effect.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        bit   mb, ml;
        mb = (sb[d].size() != 0);
        ml = mb && sb[d][0].last;
        chk($sformatf("%0d.busy", d), bsy[d], mb);
        chk($sformatf("%0d.out_valid", d), ov[d], mb);
        chk($sformatf("%0d.in_rdy", d), rdy[d], !mb || (ml && out_ready));
        if (held[d]) begin
          chk($sformatf("%0d.hold_data", d), od[d], hd[d]);
          chk($sformatf("%0d.hold_addr", d), oa[d], ha[d]);
          chk($sformatf("%0d.hold_last", d), lst[d], hl[d]);
        end
        held[d] = 1'b0;
        if (ov[d] && out_ready) begin
          if (sb[d].size() == 0) chk($sformatf("%0d.extra_beat", d), 1, 0);
          else begin
            e = sb[d].pop_front();
            chk($sformatf("%0d.data", d), od[d], e.data);
            chk($sformatf("%0d.addr", d), oa[d], e.addr);
            chk($sformatf("%0d.last", d), lst[d], e.last);
          end
        end else if (ov[d]) begin
          held[d] = 1'b1;
          hd[d]   = od[d];
          ha[d]   = oa[d];
          hl[d]   = lst[d];
        end
        if (in_val && rdy[d]) begin
          if (mb) chk($sformatf("%0d.acc_on_last", d), lst[d], 1);
          push_tile(d);
        end
      end
    end
  end

  task automatic set_tile(input logic [AW-1:0] base, input int kind);
    for (int i = 0; i < NM; i++)
      for (int j = 0; j < NP; j++)
        tile_el[i][j] = (kind == 0) ? 64'(16 * i + j) : 64'(100 + i * NP + j);
    tile_addr = base;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [AW-1:0] base, input int kind);
    bit acc;
    acc = 1'b0;
    set_tile(base, kind);
    in_val = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      if (rdy[0]) acc = 1'b1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_val = 1'b0;
  endtask

  task automatic drain(input bit bp);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      out_ready = bp ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      @(posedge clk);
      #1;
      if (!bsy[0] && !bsy[1] && !in_val) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    chk("drained_r", sb[0].size(), 0);
    chk("drained_c", sb[1].size(), 0);
    out_ready = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%0d.rst_valid", d), ov[d], 0);
      chk($sformatf("%0d.rst_last", d), lst[d], 0);
      chk($sformatf("%0d.rst_data", d), od[d], 0);
      chk($sformatf("%0d.rst_addr", d), oa[d], 0);
      chk($sformatf("%0d.rst_busy", d), bsy[d], 0);
      chk($sformatf("%0d.rst_in_rdy", d), rdy[d], 1);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; in_val = 1'b0; out_ready = 1'b0;
    set_tile(64'h0, 0);
    held[0] = 1'b0; held[1] = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Row/column-major drain at full rate.
    out_ready = 1'b1;
    send(64'h1000, 0);
    drain(1'b0);

    // Back-pressure 1,0,0,1,...
    send(64'h3000, 0);
    drain(1'b1);

    // Back-to-back: B waits with in_val held and enters on A's last beat.
    send(64'h1000, 0);
    send(64'h2000, 1);
    drain(1'b0);

    // Address wrap past 2^64.
    send(64'hFFFF_FFFF_FFFF_FFF0, 0);
    drain(1'b0);

    // Reset in the middle of a drain abandons the tile.
    send(64'h4000, 0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_outputs();
    sb[0].delete(); sb[1].delete();
    held[0] = 1'b0; held[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Recovery after reset.
    send(64'h5000, 1);
    drain(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
